branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the mispredict counter width (range 4..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, request present.
REQ-005 The block SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-006 The block SHALL have ports rs1 and rs2, input, 32 each, the compare operands.
REQ-007 The block SHALL have port funct3, input, 3, the branch type.
REQ-008 The block SHALL have ports pc and imm, input, 32 each, the branch PC and sign-extended offset.
REQ-009 The block SHALL have port pred_taken, input, 1, the fetch-stage prediction.
REQ-010 The block SHALL have port flush, input, 1, which kills the held result and any input offered in the same cycle.
REQ-011 The block SHALL have port out_valid, output, 1, registered result present.
REQ-012 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-013 The block SHALL have ports out_taken, out_mispredict and out_illegal, output, 1 each.
REQ-014 The block SHALL have port out_redirect_pc, output, 32, the correct next PC.
REQ-015 The block SHALL have port mispredict_cnt, output, CNT_W, a saturating count of retired mispredicts.

Function
REQ-016 Taken decode SHALL be:
- 000: eq
- 001: !eq
- 100: signed rs1<rs2
- 101: !(signed rs1<rs2)
- 110: unsigned rs1<rs2
- 111: !(unsigned rs1<rs2)
REQ-017 Less-than SHALL be derived from the comparator as !gt && !eq, using gts for signed and gtu for unsigned.
REQ-018 funct3 010 or 011 SHALL give taken=0 and illegal=1; all other codes give illegal=0.
REQ-019 The target SHALL be pc+imm and the fallthrough pc+4, both modulo 2^32 with carry discarded.
REQ-020 Redirect SHALL be: redirect_pc = taken ? target : fallthrough.
REQ-021 Mispredict SHALL be taken XOR pred_taken.
REQ-022 Latency SHALL be one cycle: a request accepted on edge N is visible on the out_* ports after edge N.
REQ-023 in_ready SHALL be combinational: !out_valid || out_ready, gated low while flush=1.
REQ-024 The output register SHALL be a single entry; a new accept overwrites it in the same edge the old result retires (full throughput).
REQ-025 While out_valid=1 and out_ready=0, all out_* ports SHALL hold stable.
REQ-026 When flush=1 at an edge, out_valid SHALL become 0 and no input SHALL be accepted.
REQ-027 The flush override SHALL apply even if in_valid=1 and out_ready=1 at that edge.
REQ-028 mispredict_cnt SHALL increment by one on each edge where out_valid && out_ready && out_mispredict && !flush.
REQ-029 mispredict_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 Illegal requests SHALL count as mispredicts when pred_taken=1.

Reset
REQ-031 While rst_n=0, out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc and mispredict_cnt SHALL be 0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL drop any held result without retiring it.
REQ-033 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-034 The funct3 encodings SHALL live in shared package rv_branch_pkg, alongside the 32-bit XLEN constant.
REQ-035 Comparison SHALL use one instance of the existing 32-bit comparator comp32bs, which supplies gts, gtu and eq; no other sub-module.

Verification
REQ-036 Scenario: BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> taken=1, mispredict=1, redirect=0x120, count=1.
REQ-037 Scenario: BLTU, same operands, pred=0 -> taken=0, mispredict=0, redirect=0x104.
REQ-038 Scenario: BEQ, rs1=rs2=0x5, pc=0xFFFFFFF0, imm=0x20 -> redirect=0x00000010 (wrap-around).
REQ-039 Scenario: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> back-to-back results, one per cycle.
REQ-040 Scenario: flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not accepted, count unchanged.
REQ-041 Scenario: funct3=010, pred=1 -> illegal=1, taken=0, mispredict=1; with CNT_W=4, 20 such requests -> count=15.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared RISC-V branch definitions.
//   XLEN      : datapath width used by the branch datapath.
//   funct3_e  : branch-type encodings carried in the instruction funct3 field.
//               Codes 010 and 011 are unassigned and decode as illegal.
package rv_branch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

endpackage

// File: rtl/comp32bs.sv
// 32-bit magnitude comparator supplying signed/unsigned greater-than and equality.
//   a, b : operands
//   gts  : a > b, two's-complement
//   gtu  : a > b, unsigned
//   eq   : a == b
module comp32bs (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gts,
  output logic        gtu,
  output logic        eq
);

  always_comb begin
    gts = $signed(a) > $signed(b);
    gtu = a > b;
    eq  = a == b;
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates the branch condition, computes the correct
// next PC, flags mispredictions and keeps a saturating mispredict counter.
// One-entry registered output with valid/ready handshake and full throughput.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake (in_ready is combinational)
//   rs1, rs2, funct3      : compare operands and branch type
//   pc, imm, pred_taken   : branch PC, sign-extended offset, fetch prediction
//   flush                 : kills the held result and any same-cycle input
//   out_valid / out_ready : result handshake
//   out_taken, out_mispredict, out_illegal, out_redirect_pc : registered result
//   mispredict_cnt        : saturating count of retired mispredicts
module branch_unit
  import rv_branch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic            gts, gtu, eq;
  logic            lts, ltu;
  logic            taken, illegal, mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            accept, retire;

  comp32bs u_comp (
    .a   (rs1),
    .b   (rs2),
    .gts (gts),
    .gtu (gtu),
    .eq  (eq)
  );

  always_comb begin
    lts     = !gts && !eq;
    ltu     = !gtu && !eq;
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3_e'(funct3))
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lts;
      F3_BGE:  taken = !lts;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: illegal = 1'b1;
    endcase
    mispredict  = taken ^ pred_taken;
    redirect_pc = taken ? (pc + imm) : (pc + XLEN'(4));
  end

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready && !flush;

  // Flush takes priority; an accept overwrites the entry retiring on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_mispredict  <= 1'b0;
      out_illegal     <= 1'b0;
      out_redirect_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_taken       <= taken;
      out_mispredict  <= mispredict;
      out_illegal     <= illegal;
      out_redirect_pc <= redirect_pc;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (retire && out_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule
